// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder channel scheduler.
// Any block that talks to the encoder datapath imports this package.
package rle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    localparam int CHAR_W = 7;

endpackage

// File: rtl/rle_channel_scheduler_if.sv
// Bundle of the channel request side and the encoder side of the scheduler.
// The scheduler uses the slave view; whoever drives the channels and the encoder uses the master view.
interface rle_channel_scheduler_if
    import rle_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = CHAR_W,
    parameter int CH_W   = $clog2(NUM_CH)
);

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_last;
    logic [NUM_CH-1:0]        req_ready;
    logic                     enc_valid;
    logic [DATA_W-1:0]        enc_data;
    logic                     enc_flush;
    logic [CH_W-1:0]          enc_chan;
    logic                     enc_ready;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_last, enc_ready,
        input  req_ready, enc_valid, enc_data, enc_flush, enc_chan, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, enc_ready,
        output req_ready, enc_valid, enc_data, enc_flush, enc_chan, busy
    );

endinterface

// File: rtl/rle_channel_scheduler_rr_picker.sv
// Round-robin picker: finds the first requesting channel strictly after the pointer,
// wrapping from the highest channel back to channel 0.
module rr_picker #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grantOh,
    output logic [CH_W-1:0]   o_grantIdx,
    output logic              o_anyReq
);

    // Walk the channels in priority order starting just after the pointer; the pointer itself is last.
    always_comb begin
        int idx;
        idx        = 0;
        o_grantOh  = '0;
        o_grantIdx = '0;
        o_anyReq   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(i_ptr) + k) % NUM_CH;
            if (!o_anyReq && i_req[idx]) begin
                o_anyReq       = 1'b1;
                o_grantIdx     = CH_W'(idx);
                o_grantOh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rle_channel_scheduler.sv
// Time-shares one run-length encoder between NUM_CH character streams with round-robin grants,
// closing each grant with a flush so the encoder never merges runs of different channels.
module rle_channel_scheduler
    import rle_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = CHAR_W,
    parameter int MAX_BURST = 16,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    rle_channel_scheduler_if.slave bus
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST - 1);

    sched_state_t      r_state;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   r_rrPtr;
    logic [NUM_CH-1:0] r_grantOh;
    logic [CNT_W-1:0]  r_burstCnt;

    logic [NUM_CH-1:0] w_pickOh;
    logic [CH_W-1:0]   w_pickIdx;
    logic              w_anyReq;
    logic              w_xfer;
    logic              w_closeBurst;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .i_req      (bus.req_valid),
        .i_ptr      (r_rrPtr),
        .o_grantOh  (w_pickOh),
        .o_grantIdx (w_pickIdx),
        .o_anyReq   (w_anyReq)
    );

    assign w_xfer       = (r_state == GRANT) && bus.req_valid[r_grant] && bus.enc_ready;
    assign w_closeBurst = bus.req_last[r_grant] || (r_burstCnt == BURST_END);

    // Grant lifecycle: arbitrate in IDLE, stream in GRANT, hand the run boundary to the encoder in FLUSH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantOh  <= '0;
            r_rrPtr    <= CH_W'(NUM_CH - 1);
            r_burstCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant    <= w_pickIdx;
                        r_grantOh  <= w_pickOh;
                        r_rrPtr    <= w_pickIdx;
                        r_burstCnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_burstCnt <= r_burstCnt + CNT_W'(1);
                        if (w_closeBurst) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.enc_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The data path is a pure mux on the registered grant, so a character reaches the encoder in the same cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.enc_valid = 1'b0;
        bus.enc_data  = '0;
        bus.enc_flush = 1'b0;
        bus.enc_chan  = '0;
        bus.busy      = (r_state != IDLE);
        case (r_state)
            GRANT: begin
                bus.enc_valid = bus.req_valid[r_grant];
                bus.enc_data  = bus.req_data[int'(r_grant)*DATA_W +: DATA_W];
                bus.req_ready = r_grantOh & {NUM_CH{bus.enc_ready}};
                bus.enc_chan  = r_grant;
            end
            FLUSH: begin
                bus.enc_flush = 1'b1;
                bus.enc_chan  = r_grant;
            end
            default: begin
                bus.enc_chan = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rle_channel_scheduler.sv
// Self-checking bench for rle_channel_scheduler: directed vector table, corner-case sequences,
// and randomized traffic compared cycle by cycle against a transaction-level reference model.
module tb_rle_channel_scheduler;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 7;
    localparam int MAX_BURST = 16;

    logic clock;
    logic reset_n;

    rle_channel_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    rle_channel_scheduler #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: which channel owns the encoder (-1 = nobody), whether it is closing its run,
    // the last channel that won, and how many characters the owner has moved in this grant.
    int owner;
    bit closing;
    int lastWinner;
    int moved;

    // Observations of the DUT used by the scenario-level checks.
    int  obsGrants[$];
    int  obsBursts[$];
    int  curBurst;
    int  flushXfers;
    bit  prevGrant;
    logic [3:0] lastAccept;

    // Stream driver state.
    int rem[4];
    bit endWithLast[4];
    int seq[4];

    typedef struct {
        logic [3:0] v;
        logic [6:0] ch0;
        logic       l0;
        logic       r;
        logic       expValid;
        logic [6:0] expData;
        logic       expFlush;
        logic       expBusy;
        logic [3:0] expReady;
        logic [1:0] expChan;
    } vec_t;

    vec_t vecs[6];

    task automatic checkInt(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int grantAt(input int i);
        return (i < obsGrants.size()) ? obsGrants[i] : -1;
    endfunction

    function automatic int burstAt(input int i);
        return (i < obsBursts.size()) ? obsBursts[i] : -1;
    endfunction

    task automatic clearLogs();
        obsGrants.delete();
        obsBursts.delete();
        curBurst   = 0;
        flushXfers = 0;
    endtask

    task automatic resetModel();
        owner      = -1;
        closing    = 1'b0;
        lastWinner = NUM_CH - 1;
        moved      = 0;
        prevGrant  = 1'b0;
    endtask

    // Compare every DUT output against what the model says this cycle should look like.
    task automatic checkOutput(input string tag);
        logic [3:0] eReady;
        logic       eValid, eFlush, eBusy;
        logic [6:0] eData;
        logic [1:0] eChan;
        logic [15:0] expV, actV;
        bit inGrant;
        eReady = '0;
        eValid = 1'b0;
        eFlush = 1'b0;
        eData  = '0;
        eChan  = '0;
        eBusy  = (owner >= 0);
        if (owner >= 0) begin
            eChan = 2'(owner);
            if (closing) begin
                eFlush = 1'b1;
            end else begin
                eValid        = bus.req_valid[owner];
                eData         = bus.req_data[owner*DATA_W +: DATA_W];
                eReady[owner] = bus.enc_ready;
            end
        end
        expV = {eReady, eValid, eData, eFlush, eChan, eBusy};
        actV = {bus.req_ready, bus.enc_valid, bus.enc_data, bus.enc_flush, bus.enc_chan, bus.busy};
        total++;
        if (actV !== expV) begin
            bad++;
            $display("[TB] FAIL %s t=%0t: got ready=%b valid=%b data=%h flush=%b chan=%0d busy=%b, expected ready=%b valid=%b data=%h flush=%b chan=%0d busy=%b",
                     tag, $time, bus.req_ready, bus.enc_valid, bus.enc_data, bus.enc_flush, bus.enc_chan, bus.busy,
                     eReady, eValid, eData, eFlush, eChan, eBusy);
        end
        inGrant = bus.busy && !bus.enc_flush;
        if (inGrant && !prevGrant) begin
            obsGrants.push_back(int'(bus.enc_chan));
            curBurst = 0;
        end
        if (inGrant && bus.enc_valid && bus.enc_ready) curBurst++;
        if (bus.enc_flush && bus.enc_ready) begin
            flushXfers++;
            obsBursts.push_back(curBurst);
        end
        prevGrant = inGrant;
    endtask

    // Advance the model across one rising edge using the inputs that were present before it.
    task automatic modelStep(input logic [3:0] v, input logic [3:0] l, input logic r);
        bit found;
        int idx;
        found = 1'b0;
        if (owner < 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (lastWinner + k) % NUM_CH;
                if (!found && v[idx]) begin
                    found      = 1'b1;
                    owner      = idx;
                    lastWinner = idx;
                    moved      = 0;
                end
            end
        end else if (!closing) begin
            if (v[owner] && r) begin
                moved++;
                if (l[owner] || moved == MAX_BURST) closing = 1'b1;
            end
        end else if (r) begin
            owner   = -1;
            closing = 1'b0;
        end
    endtask

    task automatic driveInputs(input logic [3:0] v, input logic [27:0] d, input logic [3:0] l, input logic r);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.enc_ready = r;
    endtask

    task automatic finishCycle(input logic [3:0] v, input logic [3:0] l, input logic r);
        lastAccept = bus.req_ready & v;
        @(posedge clock);
        modelStep(v, l, r);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] v, input logic [27:0] d,
                                 input logic [3:0] l, input logic r);
        driveInputs(v, d, l, r);
        #1;
        checkOutput(tag);
        finishCycle(v, l, r);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear before the next edge.
    task automatic applyReset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        resetModel();
        checkOutput(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic runStreams(input string tag, input int cycles, input int readyMode);
        logic [3:0]  v, l;
        logic [27:0] d;
        logic        r;
        for (int c = 0; c < cycles; c++) begin
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                v[i] = (rem[i] > 0);
                l[i] = endWithLast[i] && (rem[i] == 1);
                d[i*DATA_W +: DATA_W] = 7'(65 + (seq[i] + 7 * i) % 26);
            end
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (c % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(tag, v, d, l, r);
            for (int i = 0; i < NUM_CH; i++) begin
                if (lastAccept[i]) begin
                    rem[i]--;
                    seq[i]++;
                end
            end
        end
    endtask

    task automatic setStreams(input int r0, input int r1, input int r2, input int r3, input logic [3:0] lastMask);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
        for (int i = 0; i < NUM_CH; i++) begin
            endWithLast[i] = lastMask[i];
            seq[i]         = 0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  rv, rl;
        logic [27:0] rd;
        logic        rr;
        logic [15:0] act, exp;

        vecs[0] = '{4'b0011, 7'h41, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[1] = '{4'b0001, 7'h41, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0, 1'b1, 4'b0001, 2'd0};
        vecs[2] = '{4'b0001, 7'h41, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0, 1'b1, 4'b0001, 2'd0};
        vecs[3] = '{4'b0001, 7'h42, 1'b1, 1'b1, 1'b1, 7'h42, 1'b0, 1'b1, 4'b0001, 2'd0};
        vecs[4] = '{4'b0000, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 4'b0000, 2'd0};
        vecs[5] = '{4'b0000, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 4'b0000, 2'd0};

        reset_n = 1'b0;
        driveInputs('0, '0, '0, 1'b0);
        resetModel();
        clearLogs();
        #2;
        checkOutput("power-on reset");
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] reset in the middle of a ch1 grant");
        for (int c = 0; c < 4; c++) applyStimulus("ch1 burst", 4'b0010, 28'(7'h58) << 7, 4'b0000, 1'b1);
        checkInt("ch1 granted before reset", grantAt(0), 1);
        applyReset("mid-grant reset");

        $display("[TB] vector table: ch0 sends AAB");
        clearLogs();
        for (int i = 0; i < 6; i++) begin
            driveInputs(vecs[i].v, {14'h0, 7'h55, vecs[i].ch0}, {3'b000, vecs[i].l0}, vecs[i].r);
            #1;
            checkOutput("vector model");
            act = {bus.enc_valid, bus.enc_data, bus.enc_flush, bus.busy, bus.req_ready, bus.enc_chan};
            exp = {vecs[i].expValid, vecs[i].expData, vecs[i].expFlush, vecs[i].expBusy, vecs[i].expReady, vecs[i].expChan};
            total++;
            if (act !== exp) begin
                bad++;
                $display("[TB] FAIL vector %0d: got %h, expected %h", i, act, exp);
            end
            finishCycle(vecs[i].v, {3'b000, vecs[i].l0}, vecs[i].r);
        end

        $display("[TB] all four channels requesting");
        applyReset("reset before fairness");
        clearLogs();
        for (int c = 0; c < 15; c++) applyStimulus("all request", 4'b1111, 28'h1234567 + 28'(c), 4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus("drain", 4'b0000, '0, 4'b0000, 1'b1);
        checkInt("grant 0", grantAt(0), 0);
        checkInt("grant 1", grantAt(1), 1);
        checkInt("grant 2", grantAt(2), 2);
        checkInt("grant 3", grantAt(3), 3);
        checkInt("grant 4", grantAt(4), 0);
        checkInt("flushes per grant", flushXfers, obsGrants.size());

        $display("[TB] ch2 long stream capped at MAX_BURST");
        applyReset("reset before burst cap");
        clearLogs();
        setStreams(0, 0, 20, 0, 4'b0000);
        runStreams("ch2 stream", 3, 0);
        rem[0] = 1; endWithLast[0] = 1'b1;
        rem[3] = 1; endWithLast[3] = 1'b1;
        runStreams("ch2 stream", 40, 0);
        checkInt("cap grant count", obsGrants.size(), 4);
        checkInt("cap first owner", grantAt(0), 2);
        checkInt("cap second owner", grantAt(1), 3);
        checkInt("cap third owner", grantAt(2), 0);
        checkInt("cap regrant owner", grantAt(3), 2);
        checkInt("cap first burst", burstAt(0), MAX_BURST);
        checkInt("ch2 remaining chars", rem[2], 0);

        $display("[TB] last character on the MAX_BURST-th transfer");
        applyReset("reset before exact cap");
        clearLogs();
        setStreams(0, 16, 0, 0, 4'b0010);
        runStreams("exact cap", 22, 0);
        checkInt("exact cap flushes", flushXfers, 1);
        checkInt("exact cap burst", burstAt(0), MAX_BURST);

        $display("[TB] enc_ready toggling");
        applyReset("reset before stall");
        clearLogs();
        setStreams(0, 4, 0, 0, 4'b0010);
        runStreams("stall", 20, 1);
        checkInt("stall burst", burstAt(0), 4);
        checkInt("stall flushes", flushXfers, 1);
        checkInt("stall remaining", rem[1], 0);

        $display("[TB] granted ch3 goes quiet while ch0 waits");
        applyReset("reset before hold");
        clearLogs();
        for (int c = 0; c < 2; c++) applyStimulus("ch3 start", 4'b1000, 28'(7'h33) << 21, 4'b0000, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus("ch3 quiet", 4'b0001, 28'h0000030, 4'b0000, 1'b1);
        checkInt("hold owner count", obsGrants.size(), 1);
        applyStimulus("ch3 last", 4'b1001, (28'(7'h34) << 21) | 28'h30, 4'b1000, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus("ch0 after", 4'b0001, 28'h0000030, 4'b0000, 1'b1);
        checkInt("hold first owner", grantAt(0), 3);
        checkInt("hold next owner", grantAt(1), 0);

        $display("[TB] randomized traffic");
        applyReset("reset before random");
        for (int c = 0; c < 1500; c++) begin
            rv = 4'($urandom_range(0, 15));
            rl = 4'($urandom) & 4'($urandom);
            rd = 28'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            applyStimulus("random", rv, rd, rl, rr);
            if (c == 700) applyReset("random reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
